// File: rtl/writeback_stage.sv
// writeback_stage: stage register, load extract, rf write port, forwarding tap and instret
module writeback_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m_valid,
  output logic            m_ready,
  input  logic            m_trap,
  input  logic            m_rd_we,
  input  logic [4:0]      m_rd_addr,
  input  logic [1:0]      m_wbsel,
  input  logic [2:0]      m_funct3,
  input  logic [1:0]      m_addr_lo,
  input  logic [XLEN-1:0] m_alu_result,
  input  logic [XLEN-1:0] m_load_data,
  input  logic [XLEN-1:0] m_pc_next,
  input  logic            wb_hold,
  output logic            rf_wenble,
  output logic [4:0]      rf_rd_addr,
  output logic [XLEN-1:0] rf_datain,
  output logic            fwd_valid,
  output logic [4:0]      fwd_rd_addr,
  output logic [XLEN-1:0] fwd_data,
  output logic [63:0]     instret
);
  logic            valid_q, trap_q, rd_we_q;
  logic [4:0]      rd_addr_q;
  logic [1:0]      wbsel_q, addr_lo_q;
  logic [2:0]      funct3_q;
  logic [XLEN-1:0] alu_q, load_q, pc_q;
  logic [7:0]      ld_b;
  logic [15:0]     ld_h;
  logic [XLEN-1:0] ld_x, wdata;
  assign m_ready = ~wb_hold;
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      trap_q    <= 1'b0;
      rd_we_q   <= 1'b0;
      rd_addr_q <= '0;
      wbsel_q   <= '0;
      funct3_q  <= '0;
      addr_lo_q <= '0;
      alu_q     <= '0;
      load_q    <= '0;
      pc_q      <= '0;
      instret   <= '0;
    end else begin
      if (valid_q && !trap_q && !wb_hold)
        instret <= instret + 64'd1;
      if (!wb_hold) begin
        valid_q <= m_valid;
        if (m_valid) begin
          trap_q    <= m_trap;
          rd_we_q   <= m_rd_we;
          rd_addr_q <= m_rd_addr;
          wbsel_q   <= m_wbsel;
          funct3_q  <= m_funct3;
          addr_lo_q <= m_addr_lo;
          alu_q     <= m_alu_result;
          load_q    <= m_load_data;
          pc_q      <= m_pc_next;
        end
      end
    end
  end
  always_comb begin
    ld_b = load_q[{addr_lo_q, 3'b000} +: 8];
    ld_h = addr_lo_q[1] ? load_q[31:16] : load_q[15:0];
    ld_x = funct3_q == 3'b000 ? {{(XLEN-8){ld_b[7]}}, ld_b} :
           funct3_q == 3'b100 ? {{(XLEN-8){1'b0}}, ld_b} :
           funct3_q == 3'b001 ? {{(XLEN-16){ld_h[15]}}, ld_h} :
           funct3_q == 3'b101 ? {{(XLEN-16){1'b0}}, ld_h} : load_q;
    wdata = wbsel_q == 2'b01 ? ld_x : wbsel_q == 2'b10 ? pc_q : alu_q;
  end
  assign fwd_valid   = valid_q & rd_we_q & ~trap_q & (rd_addr_q != 5'd0);
  assign rf_wenble   = fwd_valid & ~wb_hold;
  assign rf_rd_addr  = valid_q ? rd_addr_q : 5'd0;
  assign fwd_rd_addr = rf_rd_addr;
  assign rf_datain   = valid_q ? wdata : '0;
  assign fwd_data    = rf_datain;
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: table-driven vectors plus hold, throughput, wrap and reset sequences
module tb_writeback_stage;
  logic        clk = 1'b0;
  logic        rst, m_valid, m_ready, m_trap, m_rd_we, wb_hold;
  logic [4:0]  m_rd_addr, rf_rd_addr, fwd_rd_addr;
  logic [1:0]  m_wbsel, m_addr_lo;
  logic [2:0]  m_funct3;
  logic [31:0] m_alu_result, m_load_data, m_pc_next, rf_datain, fwd_data;
  logic        rf_wenble, fwd_valid;
  logic [63:0] instret, exp_ir;
  int          n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  writeback_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .m_valid(m_valid), .m_ready(m_ready), .m_trap(m_trap),
    .m_rd_we(m_rd_we), .m_rd_addr(m_rd_addr), .m_wbsel(m_wbsel), .m_funct3(m_funct3),
    .m_addr_lo(m_addr_lo), .m_alu_result(m_alu_result), .m_load_data(m_load_data),
    .m_pc_next(m_pc_next), .wb_hold(wb_hold), .rf_wenble(rf_wenble), .rf_rd_addr(rf_rd_addr),
    .rf_datain(rf_datain), .fwd_valid(fwd_valid), .fwd_rd_addr(fwd_rd_addr),
    .fwd_data(fwd_data), .instret(instret)
  );
  typedef struct {
    logic [4:0]  rd;
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [1:0]  lo;
    logic        trap;
    logic        we;
    logic [31:0] alu;
    logic [31:0] ld;
    logic [31:0] pc;
    logic        exp_we;
    logic        exp_fwd;
    logic [31:0] exp_d;
    logic        exp_inc;
  } vec_t;
  vec_t v[13];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input vec_t x);
    m_valid = 1'b1; m_rd_addr = x.rd; m_wbsel = x.sel; m_funct3 = x.f3; m_addr_lo = x.lo;
    m_trap = x.trap; m_rd_we = x.we; m_alu_result = x.alu; m_load_data = x.ld; m_pc_next = x.pc;
  endtask
  task automatic send(input logic [4:0] rd, input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] pc);
    vec_t x;
    x = '{rd, sel, 3'b010, 2'b00, 1'b0, 1'b1, alu, 32'h0, pc, 1'b0, 1'b0, 32'h0, 1'b0};
    drive(x);
  endtask
  initial begin
    v[0]  = '{5'd5,  2'b00, 3'b010, 2'd0, 1'b0, 1'b1, 32'h0000_1234, 32'h0,         32'h0, 1'b1, 1'b1, 32'h0000_1234, 1'b1};
    v[1]  = '{5'd1,  2'b01, 3'b000, 2'd3, 1'b0, 1'b1, 32'h0,         32'h80FF_7F01, 32'h0, 1'b1, 1'b1, 32'hFFFF_FF80, 1'b1};
    v[2]  = '{5'd2,  2'b01, 3'b100, 2'd1, 1'b0, 1'b1, 32'h0,         32'h80FF_7F01, 32'h0, 1'b1, 1'b1, 32'h0000_007F, 1'b1};
    v[3]  = '{5'd6,  2'b01, 3'b001, 2'd2, 1'b0, 1'b1, 32'h0,         32'h80FF_7F01, 32'h0, 1'b1, 1'b1, 32'hFFFF_80FF, 1'b1};
    v[4]  = '{5'd8,  2'b01, 3'b101, 2'd0, 1'b0, 1'b1, 32'h0,         32'h80FF_7F01, 32'h0, 1'b1, 1'b1, 32'h0000_7F01, 1'b1};
    v[5]  = '{5'd9,  2'b01, 3'b010, 2'd0, 1'b0, 1'b1, 32'h0,         32'h80FF_7F01, 32'h0, 1'b1, 1'b1, 32'h80FF_7F01, 1'b1};
    v[6]  = '{5'd10, 2'b11, 3'b000, 2'd0, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h80FF_7F01, 32'h4, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1};
    v[7]  = '{5'd0,  2'b00, 3'b010, 2'd0, 1'b0, 1'b1, 32'h0000_00AA, 32'h0,         32'h0, 1'b0, 1'b0, 32'h0000_00AA, 1'b1};
    v[8]  = '{5'd7,  2'b00, 3'b010, 2'd0, 1'b1, 1'b1, 32'h0000_0077, 32'h0,         32'h0, 1'b0, 1'b0, 32'h0000_0077, 1'b0};
    v[9]  = '{5'd9,  2'b00, 3'b010, 2'd0, 1'b0, 1'b0, 32'h0000_0099, 32'h0,         32'h0, 1'b0, 1'b0, 32'h0000_0099, 1'b1};
    v[10] = '{5'd11, 2'b01, 3'b000, 2'd0, 1'b0, 1'b1, 32'h0,         32'h80FF_7F01, 32'h0, 1'b1, 1'b1, 32'h0000_0001, 1'b1};
    v[11] = '{5'd12, 2'b01, 3'b001, 2'd3, 1'b0, 1'b1, 32'h0,         32'h80FF_7F01, 32'h0, 1'b1, 1'b1, 32'hFFFF_80FF, 1'b1};
    v[12] = '{5'd13, 2'b01, 3'b011, 2'd1, 1'b0, 1'b1, 32'h0,         32'h1234_5678, 32'h0, 1'b1, 1'b1, 32'h1234_5678, 1'b1};
    rst = 1'b1; wb_hold = 1'b0; m_valid = 1'b0; m_trap = 1'b0; m_rd_we = 1'b0; m_rd_addr = '0;
    m_wbsel = '0; m_funct3 = '0; m_addr_lo = '0; m_alu_result = '0; m_load_data = '0; m_pc_next = '0;
    tick(); tick();
    chk("reset rf_wenble", rf_wenble, 0);
    chk("reset rf_rd_addr", rf_rd_addr, 0);
    chk("reset rf_datain", rf_datain, 0);
    chk("reset fwd_valid", fwd_valid, 0);
    chk("reset fwd_data", fwd_data, 0);
    chk("reset instret", instret, 0);
    chk("reset m_ready", m_ready, 1);
    wb_hold = 1'b1; #1;
    chk("reset m_ready held", m_ready, 0);
    wb_hold = 1'b0;
    rst = 1'b0;
    exp_ir = 0;
    for (int i = 0; i < 13; i++) begin
      drive(v[i]);
      tick();
      m_valid = 1'b0;
      chk($sformatf("v%0d rf_wenble", i), rf_wenble, v[i].exp_we);
      chk($sformatf("v%0d rf_rd_addr", i), rf_rd_addr, v[i].rd);
      chk($sformatf("v%0d rf_datain", i), rf_datain, v[i].exp_d);
      chk($sformatf("v%0d fwd_valid", i), fwd_valid, v[i].exp_fwd);
      chk($sformatf("v%0d fwd_data", i), fwd_data, v[i].exp_d);
      tick();
      exp_ir = exp_ir + v[i].exp_inc;
      chk($sformatf("v%0d instret", i), instret, exp_ir);
      chk($sformatf("v%0d bubble", i), rf_wenble, 0);
    end
    send(5'd20, 2'b00, 32'hA, 32'h0); tick();
    send(5'd21, 2'b00, 32'hB, 32'h0);
    chk("b2b first addr", rf_rd_addr, 20);
    chk("b2b first we", rf_wenble, 1);
    tick(); m_valid = 1'b0;
    chk("b2b second addr", rf_rd_addr, 21);
    chk("b2b second data", rf_datain, 32'hB);
    chk("b2b instret1", instret, exp_ir + 1);
    tick();
    exp_ir = exp_ir + 2;
    chk("b2b instret2", instret, exp_ir);
    send(5'd3, 2'b10, 32'hFFFF, 32'h104); tick();
    send(5'd8, 2'b00, 32'h5A5A, 32'h0);
    wb_hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("hold%0d rf_wenble", c), rf_wenble, 0);
      chk($sformatf("hold%0d m_ready", c), m_ready, 0);
      chk($sformatf("hold%0d fwd_valid", c), fwd_valid, 1);
      chk($sformatf("hold%0d fwd_rd_addr", c), fwd_rd_addr, 3);
      chk($sformatf("hold%0d fwd_data", c), fwd_data, 32'h104);
      tick();
      chk($sformatf("hold%0d instret", c), instret, exp_ir);
    end
    wb_hold = 1'b0; m_valid = 1'b0; #1;
    chk("release rf_wenble", rf_wenble, 1);
    chk("release rf_rd_addr", rf_rd_addr, 3);
    chk("release rf_datain", rf_datain, 32'h104);
    tick();
    exp_ir = exp_ir + 1;
    chk("release instret", instret, exp_ir);
    chk("release once", rf_wenble, 0);
    force dut.instret = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret;
    send(5'd14, 2'b00, 32'h1, 32'h0); tick(); m_valid = 1'b0;
    chk("wrap preload", instret, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    chk("wrap instret", instret, 0);
    send(5'd4, 2'b00, 32'h55, 32'h0); tick();
    m_valid = 1'b0; wb_hold = 1'b1; tick();
    chk("held before reset", fwd_valid, 1);
    rst = 1'b1; tick(); rst = 1'b0; #1;
    chk("rst hold fwd_valid", fwd_valid, 0);
    chk("rst hold rf_rd_addr", rf_rd_addr, 0);
    chk("rst hold instret", instret, 0);
    wb_hold = 1'b0; #1;
    chk("rst release rf_wenble", rf_wenble, 0);
    chk("rst release rf_datain", rf_datain, 0);
    tick();
    chk("rst release instret", instret, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
